// File: rtl/reset_sequencer_pkg.sv
// Shared types for the board reset sequencer: FSM state encoding and the
// helper used to size its counters.
package rstseq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    FILTER    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    SOFT      = 3'd4
  } state_t;

  // One counter is shared by filter, stage spacing and soft hold.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Board-side bundle of the reset sequencer: lock/soft-reset controls in,
// per-domain resets and status out.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  import rstseq_pkg::*;

  logic                  locked;
  logic                  soft_rst;
  logic                  lock_lost_clr;
  logic [NUM_STAGES-1:0] rst_stage;
  logic                  ready;
  logic                  lock_lost;
  state_t                state;

  modport master (
    input  locked, soft_rst, lock_lost_clr,
    output rst_stage, ready, lock_lost, state
  );

  modport slave (
    output locked, soft_rst, lock_lost_clr,
    input  rst_stage, ready, lock_lost, state
  );

endinterface

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input, with a
// synchronous active-low clear.
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: qualifies PLL lock, releases per-domain resets in
// index order with fixed spacing, and re-asserts all on lock loss or soft reset.
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int LOCK_STABLE = 16,
  parameter int STAGE_DELAY = 8,
  parameter int SOFT_HOLD   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  reset_sequencer_if.master bus
);

  localparam int CNT_W = cnt_width(LOCK_STABLE, STAGE_DELAY, SOFT_HOLD);
  localparam int IDX_W = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0]      FILT_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]      DLY_LAST  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(SOFT_HOLD - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ALL_RST   = '1;

  logic                  lock_s;
  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic [NUM_STAGES-1:0] stage, stage_nx;
  logic                  ready_q, ready_nx;
  logic                  lost_q, lost_nx;
  logic                  go_release, go_soft, go_lost;

  sync_2ff u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bus.locked),
    .q       (lock_s)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      idx     <= '0;
      stage   <= ALL_RST;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      stage   <= stage_nx;
      ready_q <= ready_nx;
      lost_q  <= lost_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    idx_nx     = idx;
    stage_nx   = stage;
    ready_nx   = ready_q;
    lost_nx    = lost_q & ~bus.lock_lost_clr;
    go_release = 1'b0;
    go_soft    = 1'b0;
    go_lost    = 1'b0;

    case (state)
      WAIT_LOCK: begin
        stage_nx = ALL_RST;
        ready_nx = 1'b0;
        if (lock_s) begin
          if (LOCK_STABLE == 1) begin
            go_release = 1'b1;
          end else begin
            state_nx = FILTER;
            cnt_nx   = CNT_W'(1);
          end
        end
      end
      FILTER: begin
        stage_nx = ALL_RST;
        ready_nx = 1'b0;
        if (!lock_s) state_nx = WAIT_LOCK;
        else if (cnt == FILT_LAST) go_release = 1'b1;
        else cnt_nx = cnt + 1'b1;
      end
      RELEASE: begin
        if (!lock_s) go_lost = 1'b1;
        else if (bus.soft_rst) go_soft = 1'b1;
        else if (cnt == DLY_LAST) begin
          cnt_nx = '0;
          if (idx == IDX_LAST) begin
            state_nx = RUN;
            ready_nx = 1'b1;
          end else begin
            // Released bits are the low-order zeros, so shifting clears the next one.
            idx_nx   = idx + 1'b1;
            stage_nx = stage << 1;
          end
        end else cnt_nx = cnt + 1'b1;
      end
      RUN: begin
        stage_nx = '0;
        ready_nx = 1'b1;
        if (!lock_s) go_lost = 1'b1;
        else if (bus.soft_rst) go_soft = 1'b1;
      end
      SOFT: begin
        if (!lock_s) go_lost = 1'b1;
        else if (cnt == HOLD_LAST) go_release = 1'b1;
        else cnt_nx = cnt + 1'b1;
      end
      default: begin
        state_nx = WAIT_LOCK;
        stage_nx = ALL_RST;
        ready_nx = 1'b0;
      end
    endcase

    if (go_release) begin
      state_nx = RELEASE;
      cnt_nx   = '0;
      idx_nx   = '0;
      stage_nx = ALL_RST << 1;
      ready_nx = 1'b0;
    end
    if (go_soft) begin
      state_nx = SOFT;
      cnt_nx   = '0;
      idx_nx   = '0;
      stage_nx = ALL_RST;
      ready_nx = 1'b0;
    end
    // Lock loss is evaluated last so it beats a soft request and a flag clear.
    if (go_lost) begin
      state_nx = WAIT_LOCK;
      cnt_nx   = '0;
      idx_nx   = '0;
      stage_nx = ALL_RST;
      ready_nx = 1'b0;
      lost_nx  = 1'b1;
    end
  end

  assign bus.rst_stage = stage;
  assign bus.ready     = ready_q;
  assign bus.lock_lost = lost_q;
  assign bus.state     = state;

endmodule
